// File: rtl/rr_arb_mux.sv
// Multi-channel arbiter feeding a single registered output slot.
// Round-robin or fixed-priority grant; the output register refills on the same edge it drains.
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int MODE  = 0,
    localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_sel,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] grant;
    logic [SEL_W-1:0] ptr_next;
    logic [WIDTH-1:0] grant_data;
    logic             free;
    logic             load;

    // Walk the channels backwards from ptr+NCH-1 so the last hit is the first one after ptr.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [NCH-1:0] v, input logic [SEL_W-1:0] p);
        logic [SEL_W-1:0] pick;
        int               k;
        pick = '0;
        k    = 0;
        for (int j = NCH - 1; j >= 0; j--) begin
            k = int'(p) + j;
            if (k >= NCH) begin
                k = k - NCH;
            end
            if (v[k]) begin
                pick = SEL_W'(k);
            end
        end
        return pick;
    endfunction

    function automatic logic [SEL_W-1:0] fixed_pick(input logic [NCH-1:0] v);
        logic [SEL_W-1:0] pick;
        pick = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) begin
                pick = SEL_W'(i);
            end
        end
        return pick;
    endfunction

    assign free = !out_valid || out_ready;
    assign load = free && (|in_valid) && !rst;

    always_comb begin
        grant = '0;
        if (MODE == 1) begin
            grant = fixed_pick(in_valid);
        end else begin
            grant = rr_pick(in_valid, ptr);
        end
    end

    always_comb begin
        grant_data = '0;
        in_ready   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_data  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = load;
            end
        end
    end

    // Explicit wrap keeps non-power-of-two channel counts inside 0..NCH-1.
    assign ptr_next = (grant == SEL_W'(NCH - 1)) ? '0 : grant + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (load && (MODE == 0)) begin
            ptr <= ptr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= grant_data;
            out_sel   <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Scoreboard bench: one round-robin and one fixed-priority instance share the same stimulus,
// each checked against a queue-based reference model of the arbitration rules.
module tb_rr_arb_mux;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               sel;
    } item_t;

    logic                 clk;
    logic                 rst;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_valid;
    logic                 out_ready;

    logic [NCH-1:0]   in_ready0, in_ready1;
    logic [WIDTH-1:0] out_data0, out_data1;
    logic [1:0]       out_sel0, out_sel1;
    logic             out_valid0, out_valid1;

    int checks   = 0;
    int failures = 0;

    item_t            q0[$];
    item_t            q1[$];
    int               m_ptr[2];
    bit               m_hold[2];
    logic [WIDTH-1:0] m_last_data[2];
    int               m_last_sel[2];

    rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
        .out_data(out_data0), .out_sel(out_sel0), .out_valid(out_valid0), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
        .out_data(out_data1), .out_sel(out_sel1), .out_valid(out_valid1), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Compares the visible state of one instance against the model before the coming edge.
    task automatic checkOutput(input int m, input logic [NCH-1:0] exp_ready);
        logic [NCH-1:0]   got_ready;
        logic             got_valid;
        logic [WIDTH-1:0] got_data;
        logic [1:0]       got_sel;
        got_ready = (m == 0) ? in_ready0 : in_ready1;
        got_valid = (m == 0) ? out_valid0 : out_valid1;
        got_data  = (m == 0) ? out_data0 : out_data1;
        got_sel   = (m == 0) ? out_sel0 : out_sel1;
        compare($sformatf("in_ready_m%0d", m), WIDTH'(got_ready), WIDTH'(exp_ready));
        compare($sformatf("out_valid_m%0d", m), WIDTH'(got_valid), WIDTH'(m_hold[m]));
        if (!m_hold[m]) begin
            compare($sformatf("held_data_m%0d", m), got_data, m_last_data[m]);
            compare($sformatf("held_sel_m%0d", m), WIDTH'(got_sel), WIDTH'(m_last_sel[m]));
        end
    endtask

    // Drives one cycle of inputs, checks, then advances the model across the next edge.
    task automatic applyStimulus(input logic r, input logic [NCH-1:0] v, input logic rdy, input bit rand_data);
        int       winner;
        bit       free;
        item_t    it;
        logic [NCH-1:0] exp_ready;
        @(negedge clk);
        rst       = r;
        in_valid  = v;
        out_ready = rdy;
        for (int i = 0; i < NCH; i++) begin
            in_data[i*WIDTH +: WIDTH] = rand_data ? WIDTH'($urandom) : WIDTH'(32'hA0 + i);
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            winner    = -1;
            exp_ready = '0;
            free      = !m_hold[m] || (rdy == 1'b1);
            if (!r && free && (v != 0)) begin
                for (int off = NCH - 1; off >= 0; off--) begin
                    int ch;
                    ch = (m == 0) ? (m_ptr[m] + off) % NCH : off;
                    if (v[ch]) winner = ch;
                end
                exp_ready[winner] = 1'b1;
            end
            checkOutput(m, exp_ready);
            if (r) begin
                m_hold[m] = 0;
                m_ptr[m] = 0;
                m_last_data[m] = '0;
                m_last_sel[m] = 0;
                if (m == 0) q0.delete(); else q1.delete();
            end else if (winner >= 0) begin
                it.data = in_data[winner*WIDTH +: WIDTH];
                it.sel  = winner;
                if (m == 0) q0.push_back(it); else q1.push_back(it);
                m_hold[m] = 1;
                m_last_data[m] = it.data;
                m_last_sel[m] = winner;
                if (m == 0) m_ptr[m] = (winner + 1) % NCH;
            end else if (free) begin
                m_hold[m] = 0;
            end
        end
    endtask

    // Monitor: an item is compared when the downstream actually takes it.
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && out_ready === 1'b1) begin
                if (out_valid0 === 1'b1) begin
                    if (q0.size() == 0) begin
                        compare("sb0_empty", WIDTH'(1), WIDTH'(0));
                    end else begin
                        it = q0.pop_front();
                        compare("sb0_data", out_data0, it.data);
                        compare("sb0_sel", WIDTH'(out_sel0), WIDTH'(it.sel));
                    end
                end
                if (out_valid1 === 1'b1) begin
                    if (q1.size() == 0) begin
                        compare("sb1_empty", WIDTH'(1), WIDTH'(0));
                    end else begin
                        it = q1.pop_front();
                        compare("sb1_data", out_data1, it.data);
                        compare("sb1_sel", WIDTH'(out_sel1), WIDTH'(it.sel));
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        in_data   = '0;
        for (int m = 0; m < 2; m++) begin
            m_ptr[m] = 0;
            m_hold[m] = 0;
            m_last_data[m] = '0;
            m_last_sel[m] = 0;
        end
        repeat (2) @(posedge clk);

        $display("[TB] reset with requests pending");
        repeat (2) applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);

        $display("[TB] rotation");
        repeat (5) applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);

        $display("[TB] wrap");
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b1000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);

        $display("[TB] reset mid-stall");
        applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b0110, 1'b1, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0), NCH'($urandom),
                          ($urandom_range(0, 3) != 0), 1'b1);
        end

        repeat (3) applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
        #5;
        compare("sb0_leftover", WIDTH'(q0.size()), WIDTH'(0));
        compare("sb1_leftover", WIDTH'(q1.size()), WIDTH'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width of each channel in bits.
REQ-002 Parameter NCH, default 4: number of input channels, range 1..16.
REQ-003 Parameter MODE, default 0: arbitration policy; 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 Derived constant SEL_W SHALL equal max(1, clog2(NCH)).
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with the ports named as follows:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
REQ-006 Remaining ports (name, direction, width, meaning):
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel request.
- in_ready  output  NCH  per-channel accept, combinational.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  registered output-valid flag.
- out_ready  input  1  downstream accept.

Function
REQ-007 Output register: out_data, out_sel and out_valid SHALL be flops; there SHALL be no combinational path from in_data to out_data.
REQ-008 Output register free: free = !out_valid || out_ready.
REQ-009 Load condition: load = free && (|in_valid) && !rst.
REQ-010 Grant, MODE=0: search channels ptr, ptr+1, ... NCH-1, 0, ... ptr-1 in that order; the first channel with in_valid set wins.
REQ-011 Grant, MODE=1: the lowest-index channel with in_valid set wins; ptr SHALL be ignored.
REQ-012 in_ready[i] SHALL be 1 only when load=1 and channel i is granted. in_ready SHALL be one-hot or all zero.
REQ-013 A transfer on channel i occurs when in_valid[i] && in_ready[i]. On the next edge the block SHALL load:
- out_data <= channel i data;
- out_sel <= i;
- out_valid <= 1.
REQ-014 Pointer update, MODE=0: on a transfer from channel k, ptr <= (k+1) mod NCH. When k = NCH-1, ptr SHALL wrap to 0, including non-power-of-2 NCH.
REQ-015 Pointer hold: with no transfer, ptr SHALL hold its value.
REQ-016 Drain without refill: if out_valid && out_ready && no in_valid, out_valid <= 0 on the next edge; out_data and out_sel SHALL hold their values.
REQ-017 Stall: if out_valid && !out_ready, out_data, out_sel, out_valid and ptr SHALL hold, and in_ready SHALL be all zero.
REQ-018 Simultaneous drain and refill (out_valid && out_ready && any in_valid): the next item SHALL load on the same edge, with no bubble. Sustained throughput SHALL be one item per cycle.
REQ-019 Latency: one cycle from a transfer to out_valid=1 carrying that item.
REQ-020 in_valid on a channel SHALL NOT be required to stay asserted; an unaccepted request MAY be withdrawn without effect.
REQ-021 NCH=1: channel 0 SHALL always be granted when valid; out_sel SHALL be 0 and ptr SHALL stay 0.
REQ-022 Fairness, MODE=0: with all channels continuously valid and out_ready=1, each channel SHALL be granted exactly once every NCH cycles.

Reset
REQ-023 While rst=1, on every edge:
- out_valid <= 0;
- out_data <= 0;
- out_sel <= 0;
- ptr <= 0.
REQ-024 While rst=1, in_ready SHALL be all zero, independent of in_valid and out_ready.
REQ-025 Reset asserted mid-operation SHALL discard any held output item; no transfer SHALL be reported on the reset cycle.
REQ-026 First grant after reset: in MODE=0 the search SHALL start from channel 0.

Verification
Unless stated otherwise, all scenarios run with WIDTH=32, NCH=4, MODE=0, and channel i carrying data 0xA0+i.
REQ-027 Reset check: rst=1 for 2 cycles with in_valid=1111 and out_ready=1 -> in_ready=0000, out_valid=0, out_data=0, out_sel=0 throughout.
REQ-028 Rotation: in_valid=1111 and out_ready=1 held for 5 cycles after reset -> out_sel sequence 0,1,2,3,0 and out_data sequence 0xA0, 0xA1, 0xA2, 0xA3, 0xA0 on consecutive cycles, with no bubbles.
REQ-029 Backpressure: channel 2 only valid, loaded, then out_ready=0 for 3 cycles:
- out_data=0xA2 and out_sel=2 held;
- in_ready=0000;
- on out_ready=1, the next grant is taken from ptr=3.
REQ-030 Wrap: ptr=0, only channel 3 valid -> in_ready=1000, out_sel=3 next cycle, ptr=0 afterwards.
REQ-031 Fixed priority: MODE=1, in_valid=1111, out_ready=1 for 4 cycles -> out_sel=0 every cycle and in_ready[1] never asserted.
REQ-032 Reset mid-stall: out_valid=1, out_ready=0, out_data=0xA1, then rst=1 for 1 cycle -> out_valid=0, out_data=0, ptr=0 after the edge; the first grant after reset goes to the lowest valid index.
